if_fetch_unit: RTL and testbench

//  Instruction-fetch stage: producer side of the IF/ID pipeline register.

---
 rtl/if_fetch_unit_pkg.sv | 32 +++
 rtl/if_fetch_unit_pc_reg.sv | 45 ++++
 rtl/if_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// PC/request-address update selectors and word-alignment helper.
package if_fetch_unit_pkg;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEF  = 4;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_REQ   = 2'd1,
        IF_HOLD  = 2'd2,
        IF_FLUSH = 2'd3
    } if_state_e;

    typedef enum logic [1:0] {
        PC_KEEP   = 2'd0,
        PC_NEXT   = 2'd1,
        PC_TARGET = 2'd2
    } pc_op_e;

    typedef enum logic [1:0] {
        RA_KEEP    = 2'd0,
        RA_FROM_PC = 2'd1,
        RA_TARGET  = 2'd2
    } req_op_e;

    // Branch targets are word addresses; the low two bits are discarded.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_pc_reg.sv
// Program counter and in-flight request address registers, with the
// sequential increment and branch-target alignment the fetch FSM selects.
module if_fetch_unit_pc_reg
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  pc_op_e      pc_op,
    input  req_op_e     req_op,
    input  logic [31:0] branch_target,
    output logic [31:0] req_addr,
    output logic [31:0] req_addr_next
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    logic [31:0] pc;
    logic [31:0] target_aligned;

    assign target_aligned = align_word(branch_target);
    // Wraps modulo 2^32 by construction of the 32-bit adder.
    assign req_addr_next  = req_addr + STEP;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            case (pc_op)
                PC_NEXT:   pc <= req_addr_next;
                PC_TARGET: pc <= target_aligned;
                default:   pc <= pc;
            endcase
            case (req_op)
                RA_FROM_PC: req_addr <= pc;
                RA_TARGET:  req_addr <= target_aligned;
                default:    req_addr <= req_addr;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// presents Inst / PC_addr_out to IF/ID under PCWrite stall and branch flush.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = PC_STEP_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        branchtakken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Inst,
    output logic [31:0] PC_addr_out,
    output logic        fetch_valid
);

    if_state_e   state;
    if_state_e   state_next;
    pc_op_e      pc_op;
    req_op_e     req_op;
    logic        load_inst;
    logic        drop_inst;
    logic [31:0] req_addr;
    logic [31:0] req_addr_next;

    if_fetch_unit_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clock         (clock),
        .reset         (reset),
        .pc_op         (pc_op),
        .req_op        (req_op),
        .branch_target (branch_target),
        .req_addr      (req_addr),
        .req_addr_next (req_addr_next)
    );

    assign imem_addr = req_addr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IF_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IF_IDLE: state_next = IF_REQ;
            IF_REQ: begin
                if (imem_ack) begin
                    state_next = branchtakken ? IF_REQ : IF_HOLD;
                end else if (branchtakken) begin
                    state_next = IF_FLUSH;
                end
            end
            IF_HOLD: begin
                if (branchtakken || !PCWrite) begin
                    state_next = IF_REQ;
                end
            end
            IF_FLUSH: begin
                if (imem_ack) begin
                    state_next = IF_REQ;
                end
            end
            default: state_next = IF_IDLE;
        endcase
    end

    // A branch while the request is still outstanding only retargets the PC;
    // req_addr stays put so the memory sees a stable address until it acks.
    always_comb begin
        pc_op     = PC_KEEP;
        req_op    = RA_KEEP;
        load_inst = 1'b0;
        drop_inst = 1'b0;
        case (state)
            IF_REQ: begin
                if (branchtakken) begin
                    pc_op = PC_TARGET;
                    if (imem_ack) begin
                        req_op = RA_TARGET;
                    end
                end else if (imem_ack) begin
                    load_inst = 1'b1;
                    pc_op     = PC_NEXT;
                end
            end
            IF_HOLD: begin
                if (branchtakken) begin
                    drop_inst = 1'b1;
                    pc_op     = PC_TARGET;
                    req_op    = RA_TARGET;
                end else if (!PCWrite) begin
                    drop_inst = 1'b1;
                    req_op    = RA_FROM_PC;
                end
            end
            IF_FLUSH: begin
                if (branchtakken) begin
                    pc_op = PC_TARGET;
                end
                if (imem_ack) begin
                    req_op = branchtakken ? RA_TARGET : RA_FROM_PC;
                end
            end
            default: begin
                pc_op = PC_KEEP;
            end
        endcase
    end

    // imem_req is a flop so no input reaches the memory port combinationally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            imem_req <= 1'b0;
        end else begin
            imem_req <= (state_next == IF_REQ) || (state_next == IF_FLUSH);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Inst        <= NOP_INST;
            PC_addr_out <= 32'h0000_0000;
            fetch_valid <= 1'b0;
        end else if (load_inst) begin
            Inst        <= imem_rdata;
            PC_addr_out <= req_addr_next;
            fetch_valid <= 1'b1;
        end else if (drop_inst) begin
            Inst        <= NOP_INST;
            fetch_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: scoreboarded fetches plus stall,
// branch/flush, PC wrap and asynchronous reset scenarios.
module tb_if_fetch_unit;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, PCWrite, branchtakken, imem_ack;
    logic [31:0] branch_target, imem_rdata;
    logic        imem_req, fetch_valid;
    logic [31:0] imem_addr, Inst, PC_addr_out;

    logic        reset_w, ack_w, req_w, fv_w;
    logic [31:0] rdata_w, addr_w, inst_w, pcout_w;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_out;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic fv_prev = 1'b0;

    if_fetch_unit dut (
        .clock(clock), .reset(reset), .PCWrite(PCWrite), .branchtakken(branchtakken),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .Inst(Inst),
        .PC_addr_out(PC_addr_out), .fetch_valid(fetch_valid)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clock(clock), .reset(reset_w), .PCWrite(1'b0), .branchtakken(1'b0),
        .branch_target(32'h0), .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(ack_w), .imem_rdata(rdata_w), .Inst(inst_w),
        .PC_addr_out(pcout_w), .fetch_valid(fv_w)
    );

    // Each new valid instruction (rising fetch_valid) retires one expectation.
    always @(negedge clock) begin
        if (fetch_valid === 1'b1 && fv_prev !== 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: Inst=%h PC_addr_out=%h with no fetch outstanding", Inst, PC_addr_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (Inst !== mon_e.inst || PC_addr_out !== mon_e.pc_out) begin
                    errors++;
                    $display("FAIL sb_fetch: Inst=%h PC_addr_out=%h required %h %h",
                             Inst, PC_addr_out, mon_e.inst, mon_e.pc_out);
                end
            end
        end
        fv_prev = fetch_valid;
    end

    task automatic wait_req(input logic [31:0] exp_addr);
        for (int i = 0; i < 50 && imem_req !== 1'b1; i++) @(negedge clock);
        checks++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL req_timeout: imem_req=%b required 1", imem_req);
        end
        checks++;
        if (imem_addr !== exp_addr) begin
            errors++; $display("FAIL req_addr: imem_addr=%h required %h", imem_addr, exp_addr);
        end
    endtask

    task automatic serve_one(input logic [31:0] exp_addr, input int delay, input logic [31:0] data);
        wait_req(exp_addr);
        repeat (delay) begin
            @(negedge clock);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
                errors++; $display("FAIL req_stable: req=%b addr=%h required 1 %h", imem_req, imem_addr, exp_addr);
            end
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        exp_q.push_back({data, exp_addr + 32'd4});
        @(negedge clock);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1; PCWrite = 1'b0; branchtakken = 1'b0; branch_target = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        reset_w = 1'b1; ack_w = 1'b0; rdata_w = 32'h0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: req=%b valid=%b required 0 0", imem_req, fetch_valid);
        end
        checks++;
        if (Inst !== 32'h0 || PC_addr_out !== 32'h0 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_data: Inst=%h pc_out=%h addr=%h required 0 0 0", Inst, PC_addr_out, imem_addr);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 3; k++) begin
            serve_one(32'(4 * k), 0, 32'h2002_0005);
            checks++;
            if (fetch_valid !== 1'b1 || imem_req !== 1'b0) begin
                errors++; $display("FAIL seq_hold%0d: valid=%b req=%b required 1 0", k, fetch_valid, imem_req);
            end
            @(negedge clock);
            checks++;
            if (fetch_valid !== 1'b0 || imem_req !== 1'b1) begin
                errors++; $display("FAIL seq_next%0d: valid=%b req=%b required 0 1", k, fetch_valid, imem_req);
            end
        end
    endtask

    task automatic test_stall();
        PCWrite = 1'b1;
        serve_one(32'h0C, 0, 32'h1111_2222);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (Inst !== 32'h1111_2222 || PC_addr_out !== 32'h10 || fetch_valid !== 1'b1 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d: Inst=%h pc_out=%h valid=%b req=%b required 11112222 10 1 0",
                         k, Inst, PC_addr_out, fetch_valid, imem_req);
            end
        end
        PCWrite = 1'b0;
        @(negedge clock);
        checks++;
        if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            errors++; $display("FAIL stall_resume: valid=%b req=%b addr=%h required 0 1 10", fetch_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_branch_hold();
        PCWrite = 1'b1;
        serve_one(32'h10, 0, 32'h3333_4444);
        branchtakken = 1'b1; branch_target = 32'h0000_0043;
        @(negedge clock);
        branchtakken = 1'b0; PCWrite = 1'b0;
        checks++;
        if (Inst !== 32'h0 || fetch_valid !== 1'b0 || PC_addr_out !== 32'h14) begin
            errors++; $display("FAIL br_hold_out: Inst=%h valid=%b pc_out=%h required 0 0 14", Inst, fetch_valid, PC_addr_out);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            errors++; $display("FAIL br_hold_addr: req=%b addr=%h required 1 40", imem_req, imem_addr);
        end
        serve_one(32'h40, 0, 32'h5555_6666);
    endtask

    task automatic test_branch_req_delayed();
        wait_req(32'h44);
        branchtakken = 1'b1; branch_target = 32'h80;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            branchtakken = 1'b0;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin
                errors++; $display("FAIL flush_stable%0d: req=%b addr=%h required 1 44", k, imem_req, imem_addr);
            end
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        imem_ack = 1'b0;
        checks++;
        if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            errors++; $display("FAIL flush_redirect: valid=%b req=%b addr=%h required 0 1 80", fetch_valid, imem_req, imem_addr);
        end
        serve_one(32'h80, 1, 32'h7777_8888);
    endtask

    task automatic test_branch_with_ack();
        wait_req(32'h84);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        branchtakken = 1'b1; branch_target = 32'hC1;
        @(negedge clock);
        imem_ack = 1'b0; branchtakken = 1'b0;
        checks++;
        if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hC0) begin
            errors++; $display("FAIL br_ack: valid=%b req=%b addr=%h required 0 1 c0", fetch_valid, imem_req, imem_addr);
        end
        serve_one(32'hC0, 0, 32'h9999_AAAA);
    endtask

    task automatic test_flush_double();
        wait_req(32'hC4);
        branchtakken = 1'b1; branch_target = 32'h100;
        @(negedge clock);
        branch_target = 32'h200;
        @(negedge clock);
        branchtakken = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC4) begin
            errors++; $display("FAIL flush2_stable: req=%b addr=%h required 1 c4", imem_req, imem_addr);
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_0001;
        @(negedge clock);
        imem_ack = 1'b0;
        checks++;
        if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++; $display("FAIL flush2_target: valid=%b req=%b addr=%h required 0 1 200", fetch_valid, imem_req, imem_addr);
        end
        serve_one(32'h200, 0, 32'hBBBB_CCCC);
    endtask

    task automatic test_async_reset();
        wait_req(32'h204);
        imem_ack = 1'b1; imem_rdata = 32'hEEEE_EEEE;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || Inst !== 32'h0 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL async_reset: req=%b valid=%b Inst=%h addr=%h required 0 0 0 0",
                               imem_req, fetch_valid, Inst, imem_addr);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        imem_ack = 1'b0;
        checks++;
        if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL late_ack: valid=%b req=%b addr=%h required 0 1 0", fetch_valid, imem_req, imem_addr);
        end
        serve_one(32'h0, 0, 32'h1234_5678);
    endtask

    task automatic test_wrap();
        reset_w = 1'b0;
        for (int i = 0; i < 50 && req_w !== 1'b1; i++) @(negedge clock);
        checks++;
        if (req_w !== 1'b1 || addr_w !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_req: req=%b addr=%h required 1 fffffffc", req_w, addr_w);
        end
        ack_w = 1'b1; rdata_w = 32'hCAFE_F00D;
        @(negedge clock);
        ack_w = 1'b0;
        checks++;
        if (fv_w !== 1'b1 || pcout_w !== 32'h0 || inst_w !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL wrap_out: valid=%b pc_out=%h Inst=%h required 1 0 cafef00d", fv_w, pcout_w, inst_w);
        end
        @(negedge clock);
        checks++;
        if (req_w !== 1'b1 || addr_w !== 32'h0 || fv_w !== 1'b0) begin
            errors++; $display("FAIL wrap_next: req=%b addr=%h valid=%b required 1 0 0", req_w, addr_w, fv_w);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_hold();
        test_branch_req_delayed();
        test_branch_with_ack();
        test_flush_double();
        test_async_reset();
        test_wrap();
        @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_drain: %0d fetches never delivered, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
